// File: rtl/rcc_pkg.sv
// rtl/rcc_pkg.sv - shared types, default sizes and helpers for ripple_count_capture
package rcc_pkg;

  // Default widths and settle depth
  localparam int RCC_IN_W   = 4;
  localparam int RCC_EXT_W  = 16;
  localparam int RCC_SETTLE = 2;

  // Snapshot handshake states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } rcc_state_e;

  // Bits needed for a counter that saturates at settle (settle itself must be representable)
  function automatic int stab_w(input int settle);
    int w;
    w = (settle < 1) ? 1 : $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/ripple_count_capture_if.sv
// rtl/ripple_count_capture_if.sv - snapshot request/valid/ready bus with overflow flag
interface ripple_count_capture_if #(
  parameter int EXT_W = 16
);

  logic             sample_req;
  logic             snap_valid;
  logic             snap_ready;
  logic [EXT_W-1:0] snap_count;
  logic             overflow;

  // Consumer side: requests snapshots and accepts them
  modport master (
    output sample_req,
    output snap_ready,
    input  snap_valid,
    input  snap_count,
    input  overflow
  );

  // Capture block side
  modport slave (
    input  sample_req,
    input  snap_ready,
    output snap_valid,
    output snap_count,
    output overflow
  );

endinterface

// File: rtl/rcc_settle_filter.sv
// rtl/rcc_settle_filter.sv - two-flop synchronizer plus settle filter for ripple counter outputs
module rcc_settle_filter
  import rcc_pkg::*;
#(
  parameter int IN_W   = RCC_IN_W,
  parameter int SETTLE = RCC_SETTLE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] q_in,
  output logic            stable,
  output logic            accept,
  output logic [IN_W-1:0] s2,
  output logic [IN_W-1:0] stable_val
);

  localparam int            CW     = stab_w(SETTLE);
  localparam logic [CW-1:0] SAT    = CW'(SETTLE);
  localparam logic [CW-1:0] SAT_M1 = CW'(SETTLE - 1);

  logic [IN_W-1:0] s1;
  logic [CW-1:0]   stab_cnt;
  logic            change;

  // s1 is the value s2 takes at this edge, so this flags an s2 change at the
  // very edge it happens; the counter then restarts from zero on that edge.
  assign change = (s1 != s2);

  // Acceptance is the edge on which the settle count reaches its limit
  assign accept = !change && (stab_cnt == SAT_M1);

  // Synchronizer chain, settle counter and accepted-value register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1         <= '0;
      s2         <= '0;
      stab_cnt   <= '0;
      stable_val <= '0;
      stable     <= 1'b0;
    end else begin
      s1 <= q_in;
      s2 <= s1;
      if (change) begin
        stab_cnt <= '0;
      end else if (stab_cnt != SAT) begin
        stab_cnt <= stab_cnt + 1'b1;
      end
      if (accept) begin
        stable_val <= s2;
      end
      if (change) begin
        stable <= 1'b0;
      end else if (accept) begin
        stable <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ripple_count_capture.sv
// rtl/ripple_count_capture.sv - ripple counter capture, wide extension and snapshot handshake (option: RCC_OVERFLOW_EN)
module ripple_count_capture
  import rcc_pkg::*;
#(
  parameter int IN_W   = RCC_IN_W,
  parameter int EXT_W  = RCC_EXT_W,
  parameter int SETTLE = RCC_SETTLE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_W-1:0]        q_in,
  ripple_count_capture_if.slave  bus
);

  logic             stable;
  logic             accept;
  logic [IN_W-1:0]  s2;
  logic [IN_W-1:0]  stable_val;
  logic [IN_W-1:0]  delta;
  logic [EXT_W-1:0] total;
  logic [EXT_W-1:0] total_next;
  logic [EXT_W-1:0] snap_count_q;
  logic             load_snap;
  rcc_state_e       state;
  rcc_state_e       state_next;

  rcc_settle_filter #(
    .IN_W   (IN_W),
    .SETTLE (SETTLE)
  ) u_filter (
    .clk        (clk),
    .rst        (rst),
    .q_in       (q_in),
    .stable     (stable),
    .accept     (accept),
    .s2         (s2),
    .stable_val (stable_val)
  );

  // Counts advanced since the last accepted value; modular subtraction absorbs the 15 -> 0 wrap
  assign delta = s2 - stable_val;

`ifdef RCC_OVERFLOW_EN
  logic [EXT_W:0] sum_wide;
  logic           overflow_q;

  assign sum_wide   = {1'b0, total} + {{(EXT_W + 1 - IN_W){1'b0}}, delta};
  assign total_next = accept ? sum_wide[EXT_W-1:0] : total;

  // Sticky flag: set when an accepted addition carries out of the total
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q <= 1'b0;
    end else if (accept && sum_wide[EXT_W]) begin
      overflow_q <= 1'b1;
    end
  end

  assign bus.overflow = overflow_q;
`else
  assign total_next   = accept ? (total + {{(EXT_W - IN_W){1'b0}}, delta}) : total;
  assign bus.overflow = 1'b0;
`endif

  // Extended event total, accumulating regardless of snapshot state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      total <= '0;
    end else begin
      total <= total_next;
    end
  end

  // Snapshot state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Snapshot next-state; a capture in WAIT uses the total as updated by this same edge
  always_comb begin
    state_next = state;
    load_snap  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sample_req) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (stable || accept) begin
          load_snap  = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.snap_ready) begin
          state_next = bus.sample_req ? WAIT : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Snapshot register, frozen outside of the capture edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_count_q <= '0;
    end else if (load_snap) begin
      snap_count_q <= total_next;
    end
  end

  assign bus.snap_count = snap_count_q;
  assign bus.snap_valid = (state == HOLD);

endmodule

// File: tb/tb_ripple_count_capture.sv
// tb/tb_ripple_count_capture.sv - self-checking bench for ripple_count_capture
module tb_ripple_count_capture;

`ifdef RCC_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] q_in = 4'd0;

  ripple_count_capture_if #(.EXT_W(16)) bus ();

  ripple_count_capture #(
    .IN_W   (4),
    .EXT_W  (16),
    .SETTLE (2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .q_in (q_in),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_total = 0;
  bit          exp_ovf = 1'b0;
  logic [3:0]  cur_q = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Ripple counter moves forward d counts; the model simply adds the event count
  task automatic advance(input int d);
    int unsigned s;
    s = exp_total + d;
    if (s > 32'hFFFF) exp_ovf = 1'b1;
    exp_total = s & 32'hFFFF;
    cur_q = cur_q + 4'(d);
    q_in = cur_q;
    cycles(6);
  endtask

  // Full request / wait / handshake transaction compared against the model
  task automatic snapshot(input string tag);
    int n;
    n = 0;
    bus.sample_req = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0;
    while (!bus.snap_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(bus.snap_valid), 32'd1);
    chk({tag, "_count"}, 32'(bus.snap_count), exp_total);
    bus.snap_ready = 1'b1;
    @(negedge clk);
    bus.snap_ready = 1'b0;
    chk({tag, "_released"}, 32'(bus.snap_valid), 32'd0);
  endtask

  int unsigned held;
  int unsigned diff;

  initial begin
    bus.sample_req = 1'b0;
    bus.snap_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(bus.snap_valid), 32'd0);
    chk("rst_count", 32'(bus.snap_count), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b1;
    cycles(4);

    // Slow count 0..5, request timing and long hold
    for (int i = 0; i < 5; i++) advance(1);
    bus.sample_req = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0;
    chk("t1_valid_m", 32'(bus.snap_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_m1", 32'(bus.snap_valid), 32'd1);
    chk("t1_count", 32'(bus.snap_count), 32'd5);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t1_hold_valid", 32'(bus.snap_valid), 32'd1);
      chk("t1_hold_count", 32'(bus.snap_count), 32'd5);
    end
    bus.snap_ready = 1'b1;
    @(negedge clk);
    bus.snap_ready = 1'b0;
    chk("t1_released", 32'(bus.snap_valid), 32'd0);

    // Up to 14, then through the 15 -> 0 wrap
    while (cur_q != 4'd14) advance(1);
    chk("t2_model_start", exp_total, 32'd14);
    for (int i = 0; i < 4; i++) advance(1);
    snapshot("t2_wrap");
    chk("t2_model_end", exp_total, 32'd18);

    // One-clock glitch 3 -> 7 -> 4 must count as a single step
    advance(1);
    q_in = 4'd7;
    @(negedge clk);
    q_in = 4'd4;
    cur_q = 4'd4;
    exp_total = exp_total + 1;
    cycles(6);
    snapshot("t3_glitch");

    // Back-to-back release and request while the total moves during HOLD
    bus.sample_req = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0;
    @(negedge clk);
    held = exp_total;
    chk("t4_first_count", 32'(bus.snap_count), held);
    advance(3);
    chk("t4_frozen", 32'(bus.snap_count), held);
    chk("t4_still_valid", 32'(bus.snap_valid), 32'd1);
    bus.snap_ready = 1'b1;
    bus.sample_req = 1'b1;
    @(negedge clk);
    bus.snap_ready = 1'b0;
    bus.sample_req = 1'b0;
    chk("t4_gap", 32'(bus.snap_valid), 32'd0);
    @(negedge clk);
    chk("t4_rearm_valid", 32'(bus.snap_valid), 32'd1);
    chk("t4_rearm_count", 32'(bus.snap_count), exp_total);
    bus.snap_ready = 1'b1;
    @(negedge clk);
    bus.snap_ready = 1'b0;
    chk("t4_released", 32'(bus.snap_valid), 32'd0);

    // Random advances with occasional snapshots
    for (int i = 0; i < 30; i++) begin
      advance(int'($urandom_range(1, 15)));
      if ($urandom_range(0, 2) == 0) snapshot("rnd");
    end
    snapshot("rnd_final");

    // Count up to 0xFFFE, then step across the 16-bit wrap
    while (exp_total != 32'hFFFE) begin
      diff = 32'hFFFE - exp_total;
      advance((diff > 15) ? 15 : int'(diff));
    end
    snapshot("pre_wrap");
    chk("pre_wrap_ovf", 32'(bus.overflow), 32'd0);
    advance(3);
    snapshot("post_wrap");
    chk("post_wrap_ovf", 32'(bus.overflow), 32'(exp_ovf & OVF_ON));

    // Reset while holding a snapshot of 9
    rst = 1'b0;
    q_in = 4'd0;
    cur_q = 4'd0;
    exp_total = 0;
    exp_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycles(3);
    for (int i = 0; i < 9; i++) advance(1);
    bus.sample_req = 1'b1;
    @(negedge clk);
    bus.sample_req = 1'b0;
    @(negedge clk);
    chk("t6_hold_valid", 32'(bus.snap_valid), 32'd1);
    chk("t6_hold_count", 32'(bus.snap_count), 32'd9);
    @(posedge clk);
    #2;
    rst = 1'b0;
    q_in = 4'd0;
    cur_q = 4'd0;
    exp_total = 0;
    #1;
    chk("t6_rst_valid", 32'(bus.snap_valid), 32'd0);
    chk("t6_rst_count", 32'(bus.snap_count), 32'd0);
    chk("t6_rst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycles(3);
    for (int i = 0; i < 3; i++) advance(1);
    snapshot("t6_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ripple_count_capture.md
# ripple_count_capture

Downstream consumer of the 4-bit negedge ripple up-counter. It brings the counter's asynchronous, transiently glitching outputs into the system clock domain and filters them until they have settled. It then extends the 4-bit count into a wide wrap-tolerant event total and delivers snapshots of that total to the system bus through a valid/ready handshake.

## Interface
- IN_W, 4: width of ripple counter bus.
- EXT_W, 16: width of extended event total.
- SETTLE, 2: consecutive identical synchronized samples required to accept a value (min 1).
- clk  input  1  system clock, rising edge; unrelated to the ripple counter clock.
- rst  input  1  reset, asynchronous, active-low; shared with the ripple counter.
- q_in  input  IN_W  raw ripple counter outputs, asynchronous to clk.
- sample_req  input  1  single-cycle request for a snapshot.
- snap_valid  output  1  snapshot available.
- snap_ready  input  1  consumer accepts snapshot.
- snap_count  output  EXT_W  snapshot of extended total.
- overflow  output  1  sticky: extended total has wrapped.

## Operation
- Synchronizer: two flops, s1 <= q_in, s2 <= s1.
- Settle filter: stab_cnt clears to 0 when s2 != s2_d (the previous s2), otherwise increments, saturating at SETTLE.
  - When stab_cnt becomes SETTLE, s2 is accepted: stable_val <= s2 and stable = 1.
  - stable drops to 0 on any s2 change.
- Extension: on each acceptance, delta = (s2 - stable_val) mod 2^IN_W, and total <= total + delta, modulo 2^EXT_W.
  - A delta of 0 leaves total unchanged.
  - Input requirement: the ripple counter advances fewer than 2^IN_W counts between acceptances. Violations alias silently.
- Snapshot FSM:
  - IDLE: sample_req=1 -> WAIT.
  - WAIT: at the first edge where the filter is stable (including an edge performing an acceptance), snap_count <= post-update total, snap_valid <= 1 -> HOLD.
  - HOLD: snap_count frozen. On snap_valid & snap_ready -> IDLE, or -> WAIT if sample_req=1 in the same cycle.
  - sample_req in WAIT, or in HOLD without handshake, is ignored and not queued.
- Total keeps accumulating in every FSM state; snapshots never stall accumulation.

## Timing
- Reset values:
  - s1, s2, s2_d, stable_val, stab_cnt, total, snap_count: 0.
  - stable: 0.
  - snap_valid, overflow: 0.
  - FSM: IDLE.
- Reset asserted mid-operation clears everything immediately, including a pending HOLD; the snapshot is lost. No handshake is required to leave HOLD.
- q_in stable before edge N: s1 at N, s2 at N+1, acceptance and total update at edge N+1+SETTLE.
- sample_req sampled at edge M with filter stable: snap_valid high after edge M+1. If the filter is not stable, snap_valid rises at the acceptance edge.
- snap_valid stays high until the handshake edge and is low in the following cycle (unless a back-to-back request re-arms WAIT; then it is low for at least one cycle).
- Wrap: 15 -> 0 on q_in gives delta 1. Total 0xFFFF + 1 -> 0x0000.

## Configuration
- RCC_OVERFLOW_EN defined: overflow is set at the edge where the total addition carries out of EXT_W. It stays high until reset.
- Not defined: overflow is tied to 0, and the carry logic is not built.

## Structure
- Package rcc_pkg holds:
  - the FSM state enum (IDLE, WAIT, HOLD);
  - default constants for IN_W, EXT_W and SETTLE;
  - the stab_cnt width as a function of SETTLE.
- Sub-module rcc_settle_filter contains the synchronizer and settle filter. Its outputs are stable, accept pulse, s2 and stable_val. The top level holds extension, overflow and the FSM.

## Test plan
- Reset, then q_in counts 0->5 slowly, then sample_req -> snap_count=5, snap_valid one edge after request; hold snap_ready=0 for 10 cycles -> snap_count stays 5.
- q_in 14,15,0,1,2 slowly, starting from total 14 -> total 18 (wrap delta 1 each step), snapshot 18.
- Glitch q_in 3->7->4 with the 7 held for 1 clk, SETTLE=2 -> 7 never accepted; total advances 3->4 only.
- Total preloaded to 0xFFFE by counting, then +3 -> total 0x0001; overflow=1 with RCC_OVERFLOW_EN, 0 without.
- snap_ready and sample_req high together in HOLD -> FSM re-enters WAIT; next snapshot reflects the updated total.
- Assert rst during HOLD with snap_count=9 -> snap_valid, snap_count and total are 0 immediately; sample_req after release -> snapshot of the new count.
